man_frame_rx: RTL and testbench



---
 rtl/man_frame_rx.sv | 196 +++++++++++++++++++
 tb/tb_man_frame_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/man_frame_rx.sv
// Manchester frame receiver: samples the line once per recovered half-bit,
// pairs halves into bits, hunts for the SFD and delivers a fixed-length frame.
//
// state | meaning
// HUNT  | searching the decoded bit stream for the start-of-frame delimiter
// RECV  | collecting FRAME_LEN payload bytes after a matched SFD
module man_frame_rx #(
  parameter int unsigned SAMPLE_DLY = 4,
  parameter logic [7:0]  SFD        = 8'hD5,
  parameter int unsigned FRAME_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       signal_man,
  input  logic       sync_clk,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_err,
  output logic       locked
);

  typedef enum logic {HUNT, RECV} state_t;

  localparam logic [7:0] DLY_LOAD  = 8'(SAMPLE_DLY);
  localparam logic [7:0] LAST_BYTE = 8'(FRAME_LEN - 1);

  logic       man_s1_q, man_s2_q;
  logic       sck_s1_q, sck_s2_q, sck_s3_q;
  logic       tick_q;
  logic [7:0] dly_q;
  logic       sample_stb;

  logic       phase_q, first_q;
  logic       bit_vld_q, bit_val_q, viol_q;

  state_t     state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] data_q, data_d;
  logic       dv_q, dv_d;
  logic       fs_q, fs_d;
  logic       fd_q, fd_d;
  logic       fe_q, fe_d;
  logic [7:0] shifted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      man_s1_q <= 1'b0;
      man_s2_q <= 1'b0;
      sck_s1_q <= 1'b0;
      sck_s2_q <= 1'b0;
      sck_s3_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      man_s1_q <= signal_man;
      man_s2_q <= man_s1_q;
      sck_s1_q <= sync_clk;
      sck_s2_q <= sck_s1_q;
      sck_s3_q <= sck_s2_q;
      tick_q   <= sck_s2_q ^ sck_s3_q;
    end
  end

  // Down-counter; the latest recovered edge always restarts the sample delay.
  assign sample_stb = (dly_q == 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q <= 8'd0;
    end else if (tick_q) begin
      dly_q <= DLY_LOAD;
    end else if (dly_q != 8'd0) begin
      dly_q <= dly_q - 8'd1;
    end
  end

  // On an invalid pair the second half is kept as the new first half, so a
  // stream that starts on the wrong half-bit realigns itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= 1'b0;
      first_q   <= 1'b0;
      bit_vld_q <= 1'b0;
      bit_val_q <= 1'b0;
      viol_q    <= 1'b0;
    end else begin
      bit_vld_q <= 1'b0;
      viol_q    <= 1'b0;
      if (sample_stb) begin
        if (!phase_q) begin
          first_q <= man_s2_q;
          phase_q <= 1'b1;
        end else if (first_q != man_s2_q) begin
          bit_vld_q <= 1'b1;
          bit_val_q <= man_s2_q;
          phase_q   <= 1'b0;
        end else begin
          viol_q  <= 1'b1;
          first_q <= man_s2_q;
        end
      end
    end
  end

  assign shifted = {bit_val_q, shreg_q[7:1]};

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    dv_d       = 1'b0;
    fs_d       = 1'b0;
    fd_d       = 1'b0;
    fe_d       = 1'b0;
    case (state_q)
      HUNT: begin
        if (bit_vld_q) begin
          if (shifted == SFD) begin
            fs_d       = 1'b1;
            state_d    = RECV;
            shreg_d    = 8'd0;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 8'd0;
          end else begin
            shreg_d = shifted;
          end
        end else if (viol_q) begin
          shreg_d = 8'd0;
        end
      end
      RECV: begin
        if (bit_vld_q) begin
          shreg_d = shifted;
          if (bit_cnt_q == 3'd7) begin
            data_d     = shifted;
            dv_d       = 1'b1;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = byte_cnt_q + 8'd1;
            if (byte_cnt_q == LAST_BYTE) begin
              fd_d    = 1'b1;
              state_d = HUNT;
              shreg_d = 8'd0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else if (viol_q) begin
          fe_d       = 1'b1;
          state_d    = HUNT;
          shreg_d    = 8'd0;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = 8'd0;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= HUNT;
      shreg_q    <= 8'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
      data_q     <= 8'd0;
      dv_q       <= 1'b0;
      fs_q       <= 1'b0;
      fd_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      fs_q       <= fs_d;
      fd_q       <= fd_d;
      fe_q       <= fe_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = dv_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign frame_err   = fe_q;
  // Stays up through the frame_done/frame_err cycle, drops the cycle after.
  assign locked      = (state_q == RECV) | fd_q | fe_q;

endmodule

// File: tb/tb_man_frame_rx.sv
// Directed bench for man_frame_rx: Manchester-encodes frames on the line,
// records every strobe and compares against hand-computed frame tables.
module tb_man_frame_rx;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst;
  logic man_a, sclk_a, man_b, sclk_b;
  logic [7:0] a_data, b_data;
  logic a_dv, a_fs, a_fd, a_fe, a_lk;
  logic b_dv, b_fs, b_fd, b_fe, b_lk;

  always #5 clk = ~clk;

  man_frame_rx #(.SAMPLE_DLY(4), .SFD(8'hD5), .FRAME_LEN(4)) u_dut_a (
    .clk(clk), .rst(rst), .signal_man(man_a), .sync_clk(sclk_a),
    .data_out(a_data), .data_valid(a_dv), .frame_start(a_fs),
    .frame_done(a_fd), .frame_err(a_fe), .locked(a_lk)
  );

  man_frame_rx #(.SAMPLE_DLY(4), .SFD(8'hD5), .FRAME_LEN(2)) u_dut_b (
    .clk(clk), .rst(rst), .signal_man(man_b), .sync_clk(sclk_b),
    .data_out(b_data), .data_valid(b_dv), .frame_start(b_fs),
    .frame_done(b_fd), .frame_err(b_fe), .locked(b_lk)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] qa[$];
  logic [8:0] qb[$];
  int cnt_fs_a, cnt_fe_a, cnt_fd_a;
  int cnt_fs_b, cnt_fe_b, cnt_fd_b;
  logic lk_a = 1'b0;
  logic lk_b = 1'b0;

  typedef struct {
    bit          misalign;
    logic [31:0] pl;        // byte k at pl[8k+:8], sent LSB-first
    int          viol_bit;  // payload bit replaced by "11", -1 for none
    int          n_dv;
    int          n_fe;
    int          n_fd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Record strobes; locked must rise with frame_start and hold through done/err.
  always @(negedge clk) begin
    if (rst) begin
      lk_a = 1'b0;
      lk_b = 1'b0;
    end else begin
      if (a_dv) qa.push_back({a_fd, a_data});
      if (a_fs) begin cnt_fs_a++; lk_a = 1'b1; end
      if (a_fe) cnt_fe_a++;
      if (a_fd) cnt_fd_a++;
      chk("locked_a", 32'(a_lk), 32'(lk_a));
      if (a_fd || a_fe) lk_a = 1'b0;
      if (b_dv) qb.push_back({b_fd, b_data});
      if (b_fs) begin cnt_fs_b++; lk_b = 1'b1; end
      if (b_fe) cnt_fe_b++;
      if (b_fd) cnt_fd_b++;
      chk("locked_b", 32'(b_lk), 32'(lk_b));
      if (b_fd || b_fe) lk_b = 1'b0;
    end
  end

  task automatic clr_mon();
    qa.delete();
    qb.delete();
    cnt_fs_a = 0; cnt_fe_a = 0; cnt_fd_a = 0;
    cnt_fs_b = 0; cnt_fe_b = 0; cnt_fd_b = 0;
  endtask

  task automatic half(input bit b, input logic h);
    @(negedge clk);
    if (b) begin sclk_b = ~sclk_b; man_b = h; end
    else   begin sclk_a = ~sclk_a; man_a = h; end
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic send_bit(input bit b, input logic v);
    if (v) begin half(b, 1'b0); half(b, 1'b1); end
    else   begin half(b, 1'b1); half(b, 1'b0); end
  endtask

  task automatic send_byte(input bit b, input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(b, d[i]);
  endtask

  task automatic send_hdr(input bit b);
    send_byte(b, 8'h55);
    send_byte(b, 8'h55);
    send_byte(b, 8'hD5);
  endtask

  task automatic settle();
    repeat (24) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] pl;
    pl = v.pl;
    clr_mon();
    if (v.misalign) half(1'b0, 1'b1);
    send_hdr(1'b0);
    for (int i = 0; i < 32; i++) begin
      if (i == v.viol_bit) begin
        half(1'b0, 1'b1);
        half(1'b0, 1'b1);
        break;
      end
      send_bit(1'b0, pl[i]);
    end
    settle();
    chk("frame_start_cnt", 32'(cnt_fs_a), 32'd1);
    chk("frame_err_cnt", 32'(cnt_fe_a), 32'(v.n_fe));
    chk("frame_done_cnt", 32'(cnt_fd_a), 32'(v.n_fd));
    chk("data_valid_cnt", 32'(qa.size()), 32'(v.n_dv));
    for (int k = 0; k < v.n_dv; k++) begin
      if (k < qa.size()) begin
        chk("data_out", 32'(qa[k][7:0]), 32'(pl[8*k +: 8]));
        chk("done_flag", 32'(qa[k][8]), (k == 3) ? 32'd1 : 32'd0);
      end
    end
    chk("locked_idle", 32'(a_lk), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0, 32'hCDAB3412, -1, 4, 0, 1};
    vecs[1] = '{1, 32'hCDAB3412, -1, 4, 0, 1};
    vecs[2] = '{0, 32'hCDAB3412, 11, 1, 1, 0};
    vecs[3] = '{0, 32'h00FF5AA5, -1, 4, 0, 1};
    vecs[4] = '{0, 32'hFF00D5D5, -1, 4, 0, 1};
    vecs[5] = '{1, 32'hC37E0180, -1, 4, 0, 1};

    rst = 1'b1;
    man_a = 1'b0; sclk_a = 1'b0; man_b = 1'b0; sclk_b = 1'b0;
    clr_mon();

    // Reset held with random line activity: every output stays 0.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      man_a = 1'($urandom()); sclk_a = 1'($urandom());
      man_b = 1'($urandom()); sclk_b = 1'($urandom());
      chk("rst_out_a", 32'({a_data, a_dv, a_fs, a_fd, a_fe, a_lk}), 32'd0);
      chk("rst_out_b", 32'({b_data, b_dv, b_fs, b_fd, b_fe, b_lk}), 32'd0);
    end
    man_a = 1'b0; sclk_a = 1'b0; man_b = 1'b0; sclk_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("idle_strobes_a", 32'(qa.size() + cnt_fs_a + cnt_fe_a + cnt_fd_a), 32'd0);
    chk("idle_strobes_b", 32'(qb.size() + cnt_fs_b + cnt_fe_b + cnt_fd_b), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during the first payload byte.
    clr_mon();
    send_hdr(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
    chk("locked_pre_rst", 32'(a_lk), 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("async_rst_out", 32'({a_data, a_dv, a_fs, a_fd, a_fe, a_lk}), 32'd0);
    man_a = 1'b0; sclk_a = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clr_mon();
    send_byte(1'b0, 8'h12);
    send_byte(1'b0, 8'h34);
    settle();
    chk("no_dv_without_sfd", 32'(qa.size()), 32'd0);
    chk("no_start_without_sfd", 32'(cnt_fs_a), 32'd0);
    run_vec(vecs[0]);

    // SFD value inside the payload of a two-byte frame.
    clr_mon();
    send_hdr(1'b1);
    send_byte(1'b1, 8'hD5);
    send_byte(1'b1, 8'h00);
    settle();
    chk("b_frame_start_cnt", 32'(cnt_fs_b), 32'd1);
    chk("b_frame_done_cnt", 32'(cnt_fd_b), 32'd1);
    chk("b_frame_err_cnt", 32'(cnt_fe_b), 32'd0);
    chk("b_data_valid_cnt", 32'(qb.size()), 32'd2);
    if (qb.size() == 2) begin
      chk("b_byte0", 32'(qb[0]), 32'h0D5);
      chk("b_byte1", 32'(qb[1]), 32'h100);
    end
    chk("a_quiet_during_b", 32'(qa.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
